rf_op_sequencer: RTL and testbench
==================================

// Module: rf_op_sequencer
// PURPOSE
//  Upstream controller for the 8x16 register file (regfile). It accepts one
//  register-transfer instruction per start/done handshake and sequences the
//  regfile ports (readnum, writenum, write, data_in) over several clocks.
//  It latches operands A and B from the regfile's combinational data_out,
//  computes a result C and status flags, and writes C back.
//  Sits between instruction issue and the regfile; the regfile is unchanged.
// PARAMETERS
//  DW    16  data width; must equal regfile data width
//  AW    3   register index width (8 registers)
//  IMMW  8   immediate width; sign-extended to DW
// PORTS
//  clk          in   1     rising-edge clock shared with regfile
//  reset        in   1     asynchronous, active-high reset
//  start        in   1     instruction request; accepted only in IDLE
//  op           in   2     00 MOV_IMM, 01 MOV_REG, 10 ADD, 11 CMP
//  rd           in   AW    destination register
//  rn           in   AW    first source register (ADD, CMP)
//  rm           in   AW    second source register (MOV_REG, ADD, CMP)
//  imm          in   IMMW  immediate for MOV_IMM
//  rf_data_out  in   DW    regfile data_out (combinational read of readnum)
//  readnum      out  AW    to regfile
//  writenum     out  AW    to regfile
//  write        out  1     to regfile; regfile captures on the rising edge while high
//  data_in      out  DW    to regfile; always equals register C
//  busy         out  1     high whenever state != IDLE
//  done         out  1     registered one-cycle pulse after the final state
//  Z, N, V      out  1     status: zero, negative (bit DW-1), signed overflow
// BEHAVIOUR
//  Reset (async, immediate):
//   - state goes to IDLE; A, B, C, Z, N, V and done are cleared to 0.
//   - write drops to 0 at once, so no partial write-back occurs.
//   - Regfile contents are not touched.
//  Accept: the edge where start=1 and state=IDLE. op, rd, rn and rm are
//   latched at this edge. start is ignored while busy.
//  State paths (one clock per state):
//   - MOV_IMM: IDLE->WRITE. C <= sign_ext(imm) at the accept edge.
//   - MOV_REG: IDLE->LOAD_B->EXEC->WRITE. C <= B.
//   - ADD: IDLE->LOAD_A->LOAD_B->EXEC->WRITE. C <= A+B, modulo 2^DW.
//   - CMP: IDLE->LOAD_A->LOAD_B->EXEC->IDLE. Computes A-B for the flags only;
//     C is unchanged and there is no WRITE state.
//  State actions:
//   - LOAD_A: readnum=rn; A <= rf_data_out at the exiting edge.
//   - LOAD_B: readnum=rm; B <= rf_data_out at the exiting edge.
//   - EXEC: C and flags update at the exiting edge.
//   - WRITE: write=1, writenum=rd; the regfile stores C at the exiting edge.
//  Port values outside these states: readnum=0, writenum=0, write=0.
//  Flags:
//   - Updated only in EXEC of ADD and CMP; MOV_IMM and MOV_REG hold the flags.
//   - Z = (res==0), N = res[DW-1].
//   - V for ADD: operands have equal signs and the result sign differs.
//   - V for CMP: operands have different signs and the result sign differs
//     from A's sign.
//  Latency from accept edge to return to IDLE: MOV_IMM 1, MOV_REG 3, ADD 4,
//   CMP 3. done is high for the single cycle after that edge. The next
//   accept is allowed in that same cycle.
//  Read-after-write: rn or rm may equal the previous rd. The regfile has
//   already committed that write, so the new value is read.
//  rd == rn == rm is legal; the sources are read before the write.
// STRUCTURE
//  rf_seq_pkg holds the state enum {IDLE, LOAD_A, LOAD_B, EXEC, WRITE}
//   and the op localparams.
//  Sub-module rf_seq_alu: combinational add/sub with Z/N/V outputs.
//  The state register and A/B/C/flag registers live in rf_op_sequencer.
//  The bench instantiates rf_op_sequencer together with regfile.
// TESTING
//  1. Reset, then MOV_IMM rd=3 imm=42.
//     -> write=1 for exactly one cycle with writenum=3, data_in=42.
//     -> R3=42; done pulses 1 cycle after accept.
//  2. MOV_IMM rd=1 imm=8'hF6.
//     -> data_in=16'hFFF6; R1=16'hFFF6.
//  3. ADD rd=2 rn=3 rm=1.
//     -> R2=16'd32; Z=0, N=0, V=0.
//     -> done 4 cycles after accept; write high only in the 4th cycle.
//  4. CMP rn=3 rm=3 -> Z=1, write never asserted.
//     Then R5=16'h7FFF, R6=16'hFFFF, CMP rn=5 rm=6 -> N=1, V=1, C unchanged.
//  5. MOV_REG rd=7 rm=3 -> R7=42 and flags unchanged.
//     Pulsing start during the busy cycles has no effect.
//  6. Start ADD, then assert reset during LOAD_B.
//     -> write=0, busy=0 and done=0 immediately; R2 unchanged.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared types for the register-file operation sequencer: FSM states and opcodes.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    WRITE
  } state_t;

  localparam logic [1:0] OP_MOV_IMM = 2'b00;
  localparam logic [1:0] OP_MOV_REG = 2'b01;
  localparam logic [1:0] OP_ADD     = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b11;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational add/subtract with zero, negative and signed-overflow status.
module rf_seq_alu #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] res,
  output logic          z,
  output logic          n,
  output logic          v
);

  logic [DW-1:0] b_eff;

  // Subtract as a + ~b + 1; overflow then reduces to the add rule on b_eff.
  always_comb begin
    b_eff = sub ? ~b : b;
    res   = a + b_eff + {{(DW-1){1'b0}}, sub};
    z     = (res == '0);
    n     = res[DW-1];
    v     = (a[DW-1] == b_eff[DW-1]) && (res[DW-1] != a[DW-1]);
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences regfile read/write ports for one register-transfer instruction
// per start/done handshake, computing C and Z/N/V flags.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int IMMW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [AW-1:0]   rd,
  input  logic [AW-1:0]   rn,
  input  logic [AW-1:0]   rm,
  input  logic [IMMW-1:0] imm,
  input  logic [DW-1:0]   rf_data_out,
  output logic [AW-1:0]   readnum,
  output logic [AW-1:0]   writenum,
  output logic            write,
  output logic [DW-1:0]   data_in,
  output logic            busy,
  output logic            done,
  output logic            Z,
  output logic            N,
  output logic            V
);

  state_t          state, state_nx;
  logic [1:0]      op_q;
  logic [AW-1:0]   rd_q, rn_q, rm_q;
  logic [DW-1:0]   a_q, b_q, c_q;
  logic [DW-1:0]   alu_res;
  logic            alu_z, alu_n, alu_v;

  rf_seq_alu #(.DW(DW)) u_alu (
    .a   (a_q),
    .b   (b_q),
    .sub (op_q == OP_CMP),
    .res (alu_res),
    .z   (alu_z),
    .n   (alu_n),
    .v   (alu_v)
  );

  always_comb begin
    state_nx = state;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MOV_IMM: state_nx = WRITE;
            OP_MOV_REG: state_nx = LOAD_B;
            default:    state_nx = LOAD_A;
          endcase
        end
      end
      LOAD_A: begin
        readnum  = rn_q;
        state_nx = LOAD_B;
      end
      LOAD_B: begin
        readnum  = rm_q;
        state_nx = EXEC;
      end
      EXEC:    state_nx = (op_q == OP_CMP) ? IDLE : WRITE;
      WRITE: begin
        write    = 1'b1;
        writenum = rd_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign data_in = c_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state != IDLE) && (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            rd_q <= rd;
            rn_q <= rn;
            rm_q <= rm;
            if (op == OP_MOV_IMM) c_q <= {{(DW-IMMW){imm[IMMW-1]}}, imm};
          end
        end
        LOAD_A: a_q <= rf_data_out;
        LOAD_B: b_q <= rf_data_out;
        EXEC: begin
          case (op_q)
            OP_MOV_REG: c_q <= b_q;
            OP_ADD: begin
              c_q <= alu_res;
              Z   <= alu_z;
              N   <= alu_n;
              V   <= alu_v;
            end
            OP_CMP: begin
              Z <= alu_z;
              N <= alu_n;
              V <= alu_v;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench: rf_op_sequencer driving a behavioural 8x16 register file.
module tb_rf_op_sequencer;

  logic        clk, reset, start;
  logic [1:0]  op;
  logic [2:0]  rd, rn, rm;
  logic [7:0]  imm;
  logic [15:0] rf_data_out;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [15:0] data_in;
  logic        busy, done, Z, N, V;

  logic [15:0] rf [8];
  logic        pl_en;
  logic [2:0]  pl_idx;
  logic [15:0] pl_val;

  typedef struct {
    int          id;
    logic [15:0] c;
    logic        z, n, v;
    int          lat;
    int          wr;
    logic [2:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  rf_op_sequencer #(.DW(16), .AW(3), .IMMW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rd          (rd),
    .rn          (rn),
    .rm          (rm),
    .imm         (imm),
    .rf_data_out (rf_data_out),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .Z           (Z),
    .N           (N),
    .V           (V)
  );

  // Register file: combinational read, write on rising edge, plus a bench preload path.
  assign rf_data_out = rf[readnum];
  always_ff @(posedge clk) begin
    if (write) rf[writenum] <= data_in;
    else if (pl_en) rf[pl_idx] <= pl_val;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: counts busy/write cycles per transaction and checks on each done pulse.
  initial begin
    int          busy_cnt, wr_cnt, wr_pos;
    logic [2:0]  wr_idx;
    logic [15:0] wr_data;
    exp_t        e;
    busy_cnt = 0; wr_cnt = 0; wr_pos = 0; wr_idx = '0; wr_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0; wr_cnt = 0; wr_pos = 0;
      end else begin
        if (busy) begin
          busy_cnt++;
          if (write) begin
            wr_cnt++;
            wr_pos  = busy_cnt;
            wr_idx  = writenum;
            wr_data = data_in;
          end
        end
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            $display("txn%0d: checking", e.id);
            check("latency",  busy_cnt, e.lat);
            check("write_cnt", wr_cnt, e.wr);
            check("data_in",  data_in, e.c);
            check("Z", Z, e.z);
            check("N", N, e.n);
            check("V", V, e.v);
            if (e.wr == 1) begin
              check("write_pos", wr_pos, e.lat);
              check("writenum",  wr_idx, e.rd);
              check("write_data", wr_data, e.c);
              check("rf_value",  rf[e.rd], e.c);
            end
          end
          busy_cnt = 0; wr_cnt = 0; wr_pos = 0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [2:0] d, input logic [2:0] n_,
                       input logic [2:0] m, input logic [7:0] i, input bit push, input exp_t e);
    int unsigned k;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    if (push) sb.push_back(e);
    op = o; rd = d; rn = n_; rm = m; imm = i;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic exp_t mk(int id, logic [15:0] c, logic z, logic n, logic v,
                              int lat, int wr, logic [2:0] d);
    exp_t e;
    e.id = id; e.c = c; e.z = z; e.n = n; e.v = v; e.lat = lat; e.wr = wr; e.rd = d;
    return e;
  endfunction

  task automatic drain();
    int unsigned k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; rd = '0; rn = '0; rm = '0; imm = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_data_in", data_in, 16'h0);
    check("rst_flags", {Z, N, V}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // MOV_IMM R3=42, MOV_IMM R1=-10
    issue(2'b00, 3'd3, 3'd0, 3'd0, 8'd42, 1'b1, mk(1, 16'd42, 0, 0, 0, 1, 1, 3'd3));
    issue(2'b00, 3'd1, 3'd0, 3'd0, 8'hF6, 1'b1, mk(2, 16'hFFF6, 0, 0, 0, 1, 1, 3'd1));
    // ADD R2 = R3 + R1 = 32
    issue(2'b10, 3'd2, 3'd3, 3'd1, 8'd0, 1'b1, mk(3, 16'd32, 0, 0, 0, 4, 1, 3'd2));
    // CMP R3,R3 -> Z
    issue(2'b11, 3'd0, 3'd3, 3'd3, 8'd0, 1'b1, mk(4, 16'd32, 1, 0, 0, 3, 0, 3'd0));
    // R6 = sign_ext(FF) = FFFF; flags held from CMP
    issue(2'b00, 3'd6, 3'd0, 3'd0, 8'hFF, 1'b1, mk(5, 16'hFFFF, 1, 0, 0, 1, 1, 3'd6));
    drain();
    pl_idx = 3'd5; pl_val = 16'h7FFF; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);
    check("preload_r5", rf[5], 16'h7FFF);
    // CMP 7FFF - FFFF = 8000: N=1, V=1, C unchanged
    issue(2'b11, 3'd0, 3'd5, 3'd6, 8'd0, 1'b1, mk(6, 16'hFFFF, 0, 1, 1, 3, 0, 3'd0));
    // MOV_REG R7 = R3, start pulsed while busy
    issue(2'b01, 3'd7, 3'd0, 3'd3, 8'd0, 1'b1, mk(7, 16'd42, 0, 1, 1, 3, 1, 3'd7));
    op = 2'b10; rd = 3'd4; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("r4_untouched_busy_start", busy, 1'b0);

    // ADD interrupted by reset during LOAD_B
    issue(2'b10, 3'd2, 3'd3, 3'd3, 8'd0, 1'b0, mk(0, 16'd0, 0, 0, 0, 0, 0, 3'd0));
    @(posedge clk);
    #1;
    check("in_load_b_readnum", readnum, 3'd3);
    reset = 1'b1;
    #1;
    check("async_rst_write", write, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_flags", {Z, N, V}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("r2_after_abort", rf[2], 16'd32);
    check("idle_after_abort", busy, 1'b0);
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
